// File: rtl/reg_file_param.sv
// Parametrised DEPTH x DATA_W register file: two combinational read ports, one write port,
// sequenced bulk clear with busy/done, per-entry dirty bits. Optional macro: REG_FILE_ZERO_REG_EN.
module reg_file_param #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int BYPASS = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rda1,
  input  logic [ADDR_W-1:0] rda2,
  output logic [DATA_W-1:0] rdd1,
  output logic [DATA_W-1:0] rdd2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wra,
  input  logic [DATA_W-1:0] wrd,
  output logic              wr_rej,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done,
  output logic [DEPTH-1:0]  dirty
);

`ifdef REG_FILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                clr_done_q, clr_done_d;
  logic [DEPTH-1:0]    dirty_q, dirty_d;

  logic                wra_in_range;
  logic                wra_is_zero;
  logic                wr_acc;
  logic                sweep;
  logic [DATA_W-1:0]   mem_val [DEPTH];

  // Writes to a hardwired-zero entry are accepted silently but never stored.
  assign wra_in_range = ({1'b0, wra} < DEPTH_EXT);
  assign wra_is_zero  = ZERO_REG && (wra == '0);
  assign wr_acc       = wr_en && (state_q == IDLE) && !clr_req && wra_in_range && !wra_is_zero;
  assign wr_rej       = wr_en && (busy_q || clr_req || !wra_in_range);
  assign sweep        = (state_q == CLEAR);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    clr_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      CLEAR: begin
        if (cnt_q == LAST_IDX) begin
          state_d    = IDLE;
          cnt_d      = '0;
          busy_d     = 1'b0;
          clr_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    dirty_d = dirty_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (sweep && (cnt_q == ADDR_W'(i))) dirty_d[i] = 1'b0;
      if (wr_acc && (wra == ADDR_W'(i)))  dirty_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      clr_done_q <= 1'b0;
      dirty_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      clr_done_q <= clr_done_d;
      dirty_q    <= dirty_d;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    if (ZERO_REG && (g == 0)) begin : g_zero
      assign mem_val[g] = '0;
    end else begin : g_store
      logic [DATA_W-1:0] entry_q, entry_d;

      always_comb begin
        entry_d = entry_q;
        if (sweep && (cnt_q == ADDR_W'(g))) begin
          entry_d = '0;
        end else if (wr_acc && (wra == ADDR_W'(g))) begin
          entry_d = wrd;
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) entry_q <= '0;
        else        entry_q <= entry_d;
      end

      assign mem_val[g] = entry_q;
    end
  end

  // Read priority: stored value, then same-cycle forward, then sweep blanking.
  always_comb begin
    rdd1 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rda1 == ADDR_W'(i)) rdd1 = mem_val[i];
    end
    if ((BYPASS != 0) && wr_acc && (wra == rda1)) rdd1 = wrd;
    if (busy_q) rdd1 = '0;
  end

  always_comb begin
    rdd2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rda2 == ADDR_W'(i)) rdd2 = mem_val[i];
    end
    if ((BYPASS != 0) && wr_acc && (wra == rda2)) rdd2 = wrd;
    if (busy_q) rdd2 = '0;
  end

  assign busy     = busy_q;
  assign clr_done = clr_done_q;
  assign dirty    = dirty_q;

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: default, BYPASS=1 and DEPTH=6 instances share stimulus.
module tb_reg_file_param;

`ifdef REG_FILE_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [2:0] rda1, rda2, wra;
  logic [3:0] wrd;
  logic       wr_en, clr_req;

  logic [3:0] a_rdd1, a_rdd2, b_rdd1, b_rdd2, c_rdd1, c_rdd2;
  logic       a_rej, b_rej, c_rej;
  logic       a_busy, b_busy, c_busy;
  logic       a_done, b_done, c_done;
  logic [7:0] a_dirty, b_dirty;
  logic [5:0] c_dirty;

  int n_chk;
  int n_bad;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  reg_file_param u_dut (
    .clk(clk), .reset(reset), .rda1(rda1), .rda2(rda2), .rdd1(a_rdd1), .rdd2(a_rdd2),
    .wr_en(wr_en), .wra(wra), .wrd(wrd), .wr_rej(a_rej), .clr_req(clr_req),
    .busy(a_busy), .clr_done(a_done), .dirty(a_dirty)
  );

  reg_file_param #(.BYPASS(1)) u_byp (
    .clk(clk), .reset(reset), .rda1(rda1), .rda2(rda2), .rdd1(b_rdd1), .rdd2(b_rdd2),
    .wr_en(wr_en), .wra(wra), .wrd(wrd), .wr_rej(b_rej), .clr_req(clr_req),
    .busy(b_busy), .clr_done(b_done), .dirty(b_dirty)
  );

  reg_file_param #(.DEPTH(6)) u_d6 (
    .clk(clk), .reset(reset), .rda1(rda1), .rda2(rda2), .rdd1(c_rdd1), .rdd2(c_rdd2),
    .wr_en(wr_en), .wra(wra), .wrd(wrd), .wr_rej(c_rej), .clr_req(clr_req),
    .busy(c_busy), .clr_done(c_done), .dirty(c_dirty)
  );

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [2:0] a, input logic [3:0] d);
    wr_en = 1'b1;
    wra   = a;
    wrd   = d;
    tick();
    wr_en = 1'b0;
  endtask

  int nb8, nb6, nd8, nd6;

  initial begin
    n_chk = 0; n_bad = 0;
    reset = 1'b0; wr_en = 1'b0; clr_req = 1'b0;
    rda1 = 3'd3; rda2 = 3'd0; wra = 3'd0; wrd = 4'h0;
    #2;
    check("reset_rdd1", a_rdd1, 4'h0);
    check("reset_rdd2", a_rdd2, 4'h0);
    check("reset_busy", a_busy, 1'b0);
    check("reset_done", a_done, 1'b0);
    check("reset_dirty", a_dirty, 8'h00);
    tick(); tick();
    reset = 1'b1;

    // basic write and dual read, bypass vs non-bypass visibility
    wr_en = 1'b1; wra = 3'd5; wrd = 4'h7; rda1 = 3'd5; rda2 = 3'd5;
    #1;
    check("nobyp_old", a_rdd1, 4'h0);
    check("byp_rd1", b_rdd1, 4'h7);
    check("byp_rd2", b_rdd2, 4'h7);
    check("wr5_rej", a_rej, 1'b0);
    tick();
    wr_en = 1'b0;
    #1;
    check("rd5_p1", a_rdd1, 4'h7);
    check("rd5_p2", a_rdd2, 4'h7);
    check("dirty5", a_dirty, 8'b0010_0000);
    check("d6_dirty5", c_dirty, 6'b10_0000);

    wr_en = 1'b1; wra = 3'd2; wrd = 4'h9; rda1 = 3'd2; rda2 = 3'd5;
    #1;
    check("nobyp_old2", a_rdd1, 4'h0);
    check("byp_new2", b_rdd1, 4'h9);
    check("byp_other", b_rdd2, 4'h7);
    tick();
    wr_en = 1'b0;
    #1;
    check("nobyp_next", a_rdd1, 4'h9);

    // asynchronous reset between edges
    rda1 = 3'd3;
    write(3'd3, 4'hA);
    check("rd3_a", a_rdd1, 4'hA);
    check("dirty_2c", a_dirty, 8'h2C);
    reset = 1'b0;
    #1;
    check("async_rdd1", a_rdd1, 4'h0);
    check("async_dirty", a_dirty, 8'h00);
    check("async_busy", a_busy, 1'b0);
    #2 reset = 1'b1;
    tick();

    // out-of-range on the DEPTH=6 instance
    wr_en = 1'b1; wra = 3'd7; wrd = 4'h3; rda1 = 3'd7;
    #1;
    check("d6_oor_rej", c_rej, 1'b1);
    check("d8_inr_rej", a_rej, 1'b0);
    check("d6_oor_rd", c_rdd1, 4'h0);
    tick();
    wr_en = 1'b0;
    #1;
    check("d8_rd7", a_rdd1, 4'h3);
    check("d6_rd7", c_rdd1, 4'h0);
    check("d6_dirty_oor", c_dirty, 6'h00);
    check("d8_dirty7", a_dirty, 8'h80);

    // entry 0 (hardwired zero when the macro is defined)
    wr_en = 1'b1; wra = 3'd0; wrd = 4'h5; rda1 = 3'd0;
    #1;
    check("z_rej", a_rej, 1'b0);
    check("z_byp", b_rdd1, ZR ? 4'h0 : 4'h5);
    tick();
    wr_en = 1'b0;
    #1;
    check("z_rd", a_rdd1, ZR ? 4'h0 : 4'h5);
    check("z_dirty", a_dirty, ZR ? 8'h80 : 8'h81);

    // fill every entry
    for (int i = 0; i < 8; i++) write(3'(i), 4'(i + 1));
    rda1 = 3'd4; rda2 = 3'd7;
    #1;
    check("fill_rd4", a_rdd1, 4'h5);
    check("fill_rd7", a_rdd2, 4'h8);
    check("fill_dirty", a_dirty, ZR ? 8'hFE : 8'hFF);
    check("fill_d6_dirty", c_dirty, ZR ? 6'h3E : 6'h3F);

    // clear wins over a simultaneous write, then the sweep
    clr_req = 1'b1; wr_en = 1'b1; wra = 3'd2; wrd = 4'hF;
    #1;
    check("clr_wr_rej", a_rej, 1'b1);
    tick();
    wra = 3'd1;
    nb8 = 0; nb6 = 0; nd8 = 0; nd6 = 0;
    for (int k = 0; k < 20; k++) begin
      if (a_busy) begin
        nb8++;
        check("sweep_rd1", a_rdd1, 4'h0);
        check("sweep_rd2", a_rdd2, 4'h0);
      end
      if (c_busy) nb6++;
      if (a_done) nd8++;
      if (c_done) nd6++;
      if (k == 2) begin
        check("sweep_wr_rej", a_rej, 1'b1);
        clr_req = 1'b0;
      end
      if (k == 4) wr_en = 1'b0;
      tick();
    end
    check("busy_cycles8", nb8, 8);
    check("done_pulses8", nd8, 1);
    check("busy_cycles6", nb6, 6);
    check("done_pulses6", nd6, 1);
    check("clr_dirty", a_dirty, 8'h00);
    check("clr_d6_dirty", c_dirty, 6'h00);
    for (int i = 0; i < 8; i++) begin
      rda1 = 3'(i);
      #1;
      check("clr_entry", a_rdd1, 4'h0);
    end

    // reset during a sweep: no done pulse afterwards
    rda1 = 3'd3;
    write(3'd3, 4'h6);
    check("pre_dirty", a_dirty, 8'h08);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    tick(); tick();
    check("mid_busy", a_busy, 1'b1);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", a_busy, 1'b0);
    check("mid_rst_dirty", a_dirty, 8'h00);
    check("mid_rst_rd", a_rdd1, 4'h0);
    #2 reset = 1'b1;
    nd8 = 0; nb8 = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (a_done) nd8++;
      if (a_busy) nb8++;
    end
    check("mid_no_done", nd8, 0);
    check("mid_no_busy", nb8, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
